smi_host_bridge: RTL and testbench
==================================

Name: smi_host_bridge

Overview:
- Upstream feeder for the SCR file.
- Converts a narrow 32-bit host word stream (command, then data words) into single 64-bit SMI requests (rw, addr, data).
- Returns SMI read responses to the host as two 32-bit words, low half first.
- Sits between the host/serial link adapter and the SCR file's SMI request/response port; one outstanding SMI transaction at a time.

Parameters:
- ADDR_W, 6, SMI address width; the low ADDR_W bits of the command word.
- HOST_W, 32, host word width.
- DATA_W, 64, SMI data width; fixed at 2*HOST_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_host_in_valid  in  1  host word valid.
- io_host_in_ready  out  1  bridge accepts host word.
- io_host_in_bits  in  HOST_W  host word (command or data).
- io_host_out_valid  out  1  response word valid.
- io_host_out_ready  in  1  host accepts response word.
- io_host_out_bits  out  HOST_W  response word.
- io_smi_req_valid  out  1  SMI request valid.
- io_smi_req_ready  in  1  SCR file accepts request.
- io_smi_req_bits_rw  out  1  1 = write, 0 = read.
- io_smi_req_bits_addr  out  ADDR_W  register index.
- io_smi_req_bits_data  out  DATA_W  write data (don't-care for reads).
- io_smi_resp_valid  in  1  SMI response valid.
- io_smi_resp_ready  out  1  bridge accepts response.
- io_smi_resp_bits  in  DATA_W  SMI response data.
- io_busy  out  1  state != IDLE.

Behaviour:
- Handshakes: a transfer occurs on a cycle with valid & ready. All outputs are registered state or decoded from registered state only; no combinational path from any input to any output.
- Command word format: bit[HOST_W-1] = rw; bits[ADDR_W-1:0] = addr; all other bits ignored.
- State machine: IDLE, WLO, WHI, REQ, RESP, RLO, RHI.
- IDLE: in_ready=1. On host word accept, latch rw and addr. If rw=1 go to WLO, else go to REQ.
- WLO: in_ready=1. On accept, data[31:0] <= word; go to WHI.
- WHI: in_ready=1. On accept, data[63:32] <= word; go to REQ.
- REQ: smi_req_valid=1 with the latched rw/addr/data, held stable until accepted. On smi_req_ready, go to RESP.
- RESP: smi_resp_ready=1. On resp fire:
  - read: latch resp_bits; go to RLO.
  - write: discard data; go to IDLE. The SCR file answers every request, so the write response must be consumed.
- RLO: out_valid=1, out_bits = resp[31:0]. On out fire go to RHI.
- RHI: out_valid=1, out_bits = resp[63:32]. On out fire go to IDLE.
- in_ready=0 in REQ, RESP, RLO and RHI: host words stall and none are dropped.
- Latency:
  - Read: command accept at cycle t gives smi_req_valid at t+1. With the SCR file (req_ready=1, resp one cycle after accept), resp fires at t+2 and the first out word is valid at t+3.
  - Write: the request is issued the cycle after the high data word is accepted.
- out_valid may stay high across stalls; out_bits must not change while out_valid=1 and out_ready=0.
- A resp_valid outside RESP is ignored (resp_ready=0).
- Reset (asserted low, asynchronous, any state, mid-transaction included):
  - state=IDLE, in_ready=1, out_valid=0, smi_req_valid=0, smi_resp_ready=0, io_busy=0.
  - rw, addr, data and response registers cleared to 0; out_bits=0.
  - The partial transaction is abandoned; no SMI request is emitted after reset deassertion until a new command arrives.
- Back-to-back: a new command is accepted in the cycle after IDLE is re-entered; no command is accepted in the same cycle the final out word fires.

Test Plan:
- Read: host cmd 0x00000005 (read addr 5), SCR rdata_5 = 0x1122334455667788 → SMI req rw=0 addr=5; host receives 0x55667788 then 0x11223344; io_busy returns to 0.
- Write: host words 0x8000003F, 0xDEADBEEF, 0xCAFEF00D → SMI req rw=1 addr=63 data=0xCAFEF00DDEADBEEF; response consumed; no host output word; in_ready returns to 1.
- Backpressure: read with out_ready held 0 for 10 cycles → out_valid stays 1 and out_bits stays at the low word throughout; smi_req_ready held 0 for 5 cycles → req fields stable and in_ready=0.
- Ignored bits: cmd 0x7FFFFFC2 → read of addr 2 (upper non-rw bits ignored).
- Reset mid-op: assert reset in WHI after 0x80000001, 0x12345678 → all outputs at reset values immediately; after release, no SMI request is issued; a following read of addr 1 completes normally.
- Stream: 4 back-to-back reads to addrs 0..3 with the host driving continuously → 8 response words in order, with no loss or duplication.

Source files
------------

// File: rtl/smi_host_bridge.sv
// -----------------------------------------------------------------------------
// smi_host_bridge
//
// Upstream feeder for the SCR file. It takes a 32-bit host word stream and
// assembles it into single 64-bit SMI requests. A read response comes back to
// the host as two 32-bit words, low half first. Only one SMI transaction is
// outstanding at any time.
//
// Host command word: bit[HOST_W-1] = rw (1 = write), bits[ADDR_W-1:0] = addr.
// All other bits are ignored. A write command is followed by two data words,
// low half first.
//
// Ports
//   clk, reset                   clock; asynchronous active-low reset
//   io_host_in_*                 host -> bridge word stream (valid/ready)
//   io_host_out_*                bridge -> host response words (valid/ready)
//   io_smi_req_*                 SMI request to the SCR file (rw/addr/data)
//   io_smi_resp_*                SMI response from the SCR file
//   io_busy                      high whenever the FSM is outside IDLE
//
// Every output is either a flop or a decode of flops. No input reaches an
// output in the same cycle.
// -----------------------------------------------------------------------------
module smi_host_bridge #(
  parameter int ADDR_W = 6,
  parameter int HOST_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              io_host_in_valid,
  output logic              io_host_in_ready,
  input  logic [HOST_W-1:0] io_host_in_bits,

  output logic              io_host_out_valid,
  input  logic              io_host_out_ready,
  output logic [HOST_W-1:0] io_host_out_bits,

  output logic              io_smi_req_valid,
  input  logic              io_smi_req_ready,
  output logic              io_smi_req_bits_rw,
  output logic [ADDR_W-1:0] io_smi_req_bits_addr,
  output logic [DATA_W-1:0] io_smi_req_bits_data,

  input  logic              io_smi_resp_valid,
  output logic              io_smi_resp_ready,
  input  logic [DATA_W-1:0] io_smi_resp_bits,

  output logic              io_busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WLO  = 3'd1,
    ST_WHI  = 3'd2,
    ST_REQ  = 3'd3,
    ST_RESP = 3'd4,
    ST_RLO  = 3'd5,
    ST_RHI  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                rw_q,    rw_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [DATA_W-1:0]   resp_q,  resp_d;

  logic                in_ready;
  logic                in_fire;

  // The host may push words only while a command or its data is being
  // collected; in every other state it is stalled, so nothing is dropped.
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_WLO) || (state_q == ST_WHI);
  assign in_fire  = io_host_in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    resp_d  = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          rw_d    = io_host_in_bits[HOST_W-1];
          addr_d  = io_host_in_bits[ADDR_W-1:0];
          state_d = io_host_in_bits[HOST_W-1] ? ST_WLO : ST_REQ;
        end
      end
      ST_WLO: begin
        if (in_fire) begin
          data_d[HOST_W-1:0] = io_host_in_bits;
          state_d            = ST_WHI;
        end
      end
      ST_WHI: begin
        if (in_fire) begin
          data_d[DATA_W-1:HOST_W] = io_host_in_bits;
          state_d                 = ST_REQ;
        end
      end
      ST_REQ: begin
        if (io_smi_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Writes are answered too; that response is consumed and dropped.
        if (io_smi_resp_valid) begin
          if (rw_q) begin
            state_d = ST_IDLE;
          end else begin
            resp_d  = io_smi_resp_bits;
            state_d = ST_RLO;
          end
        end
      end
      ST_RLO: begin
        if (io_host_out_ready) begin
          state_d = ST_RHI;
        end
      end
      ST_RHI: begin
        if (io_host_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  assign io_host_in_ready     = in_ready;

  // The response register only changes in RESP, so out_bits is stable for as
  // long as a word is being offered.
  assign io_host_out_valid    = (state_q == ST_RLO) || (state_q == ST_RHI);
  assign io_host_out_bits     = (state_q == ST_RHI) ? resp_q[DATA_W-1:HOST_W]
                                                    : resp_q[HOST_W-1:0];

  assign io_smi_req_valid     = (state_q == ST_REQ);
  assign io_smi_req_bits_rw   = rw_q;
  assign io_smi_req_bits_addr = addr_q;
  assign io_smi_req_bits_data = data_q;

  assign io_smi_resp_ready    = (state_q == ST_RESP);

  assign io_busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_smi_host_bridge.sv
module tb_smi_host_bridge;

  localparam int ADDR_W = 6;
  localparam int HOST_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_host_in_valid;
  logic              io_host_in_ready;
  logic [HOST_W-1:0] io_host_in_bits;
  logic              io_host_out_valid;
  logic              io_host_out_ready;
  logic [HOST_W-1:0] io_host_out_bits;
  logic              io_smi_req_valid;
  logic              io_smi_req_ready;
  logic              io_smi_req_bits_rw;
  logic [ADDR_W-1:0] io_smi_req_bits_addr;
  logic [DATA_W-1:0] io_smi_req_bits_data;
  logic              io_smi_resp_valid;
  logic              io_smi_resp_ready;
  logic [DATA_W-1:0] io_smi_resp_bits;
  logic              io_busy;

  always #5 clk = ~clk;

  smi_host_bridge #(.ADDR_W(ADDR_W), .HOST_W(HOST_W), .DATA_W(DATA_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .io_host_in_valid     (io_host_in_valid),
    .io_host_in_ready     (io_host_in_ready),
    .io_host_in_bits      (io_host_in_bits),
    .io_host_out_valid    (io_host_out_valid),
    .io_host_out_ready    (io_host_out_ready),
    .io_host_out_bits     (io_host_out_bits),
    .io_smi_req_valid     (io_smi_req_valid),
    .io_smi_req_ready     (io_smi_req_ready),
    .io_smi_req_bits_rw   (io_smi_req_bits_rw),
    .io_smi_req_bits_addr (io_smi_req_bits_addr),
    .io_smi_req_bits_data (io_smi_req_bits_data),
    .io_smi_resp_valid    (io_smi_resp_valid),
    .io_smi_resp_ready    (io_smi_resp_ready),
    .io_smi_resp_bits     (io_smi_resp_bits),
    .io_busy              (io_busy)
  );

  typedef struct packed {
    logic        rw;
    logic [5:0]  addr;
    logic [63:0] data;
  } req_t;

  // Reference model: expected SMI requests and host output words, derived
  // from the host word stream and a model of the register contents.
  req_t        exp_req_q[$];
  logic [31:0] exp_out_q[$];
  logic [31:0] host_q[$];
  logic [63:0] ref_mem [64];
  // Register contents as seen by the emulated SCR file.
  logic [63:0] scr_mem [64];

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;
  int out_cnt  = 0;

  bit req_rdy_en = 1'b1;
  bit out_rdy_en = 1'b1;
  bit rand_rdy   = 1'b0;
  bit host_en    = 1'b1;

  bit in_f, req_f, resp_f, out_f;
  bit stall_out_prev = 1'b0;
  bit stall_req_prev = 1'b0;
  logic [31:0] prev_out_bits;
  logic [70:0] prev_req;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_host();
    if (host_q.size() > 0 && host_en) begin
      io_host_in_valid = 1'b1;
      io_host_in_bits  = host_q[0];
    end else begin
      io_host_in_valid = 1'b0;
      io_host_in_bits  = '0;
    end
  endtask

  task automatic send_read(input logic [31:0] cmd);
    req_t e;
    e.rw   = 1'b0;
    e.addr = cmd[5:0];
    e.data = '0;
    host_q.push_back(cmd);
    exp_req_q.push_back(e);
    exp_out_q.push_back(ref_mem[cmd[5:0]][31:0]);
    exp_out_q.push_back(ref_mem[cmd[5:0]][63:32]);
    drive_host();
  endtask

  task automatic send_write(input logic [31:0] cmd, input logic [31:0] lo, input logic [31:0] hi);
    req_t e;
    e.rw   = 1'b1;
    e.addr = cmd[5:0];
    e.data = {hi, lo};
    host_q.push_back(cmd);
    host_q.push_back(lo);
    host_q.push_back(hi);
    exp_req_q.push_back(e);
    ref_mem[cmd[5:0]] = {hi, lo};
    drive_host();
  endtask

  // One clock: observe at the falling edge, then update every driven input
  // (host stream, SCR emulator, ready signals) just after the rising edge.
  task automatic cycle();
    req_t e;
    @(negedge clk);
    in_f   = io_host_in_valid  && io_host_in_ready;
    req_f  = io_smi_req_valid  && io_smi_req_ready;
    resp_f = io_smi_resp_valid && io_smi_resp_ready;
    out_f  = io_host_out_valid && io_host_out_ready;

    if (stall_out_prev) begin
      check("out_hold_valid", 64'(io_host_out_valid), 64'd1);
      check("out_hold_bits", 64'(io_host_out_bits), 64'(prev_out_bits));
    end
    if (stall_req_prev) begin
      check("req_hold_valid", 64'(io_smi_req_valid), 64'd1);
      check("req_hold_fields", 64'({io_smi_req_bits_rw, io_smi_req_bits_addr} != prev_req[70:64]), 64'd0);
      check("req_hold_data", io_smi_req_bits_data, prev_req[63:0]);
    end
    if (io_smi_req_valid || io_smi_resp_ready || io_host_out_valid)
      check("in_ready_stalled", 64'(io_host_in_ready), 64'd0);

    if (req_f) begin
      req_cnt++;
      check("req_expected", 64'(exp_req_q.size() > 0), 64'd1);
      if (exp_req_q.size() > 0) begin
        e = exp_req_q.pop_front();
        check("req_rw", 64'(io_smi_req_bits_rw), 64'(e.rw));
        check("req_addr", 64'(io_smi_req_bits_addr), 64'(e.addr));
        if (e.rw) check("req_data", io_smi_req_bits_data, e.data);
      end
    end
    if (out_f) begin
      out_cnt++;
      check("out_expected", 64'(exp_out_q.size() > 0), 64'd1);
      if (exp_out_q.size() > 0)
        check("out_word", 64'(io_host_out_bits), 64'(exp_out_q.pop_front()));
    end

    stall_out_prev = io_host_out_valid && !io_host_out_ready;
    prev_out_bits  = io_host_out_bits;
    stall_req_prev = io_smi_req_valid && !io_smi_req_ready;
    prev_req       = {io_smi_req_bits_rw, io_smi_req_bits_addr, io_smi_req_bits_data};

    @(posedge clk);
    #1;
    if (in_f) void'(host_q.pop_front());
    if (resp_f) io_smi_resp_valid = 1'b0;
    if (req_f) begin
      if (io_smi_req_bits_rw) begin
        scr_mem[io_smi_req_bits_addr] = io_smi_req_bits_data;
        io_smi_resp_bits = {$urandom, $urandom};
      end else begin
        io_smi_resp_bits = scr_mem[io_smi_req_bits_addr];
      end
      io_smi_resp_valid = 1'b1;
    end
    if (rand_rdy) begin
      io_smi_req_ready  = ($urandom_range(0, 3) != 0);
      io_host_out_ready = ($urandom_range(0, 3) != 0);
      host_en           = ($urandom_range(0, 3) != 0);
    end else begin
      io_smi_req_ready  = req_rdy_en;
      io_host_out_ready = out_rdy_en;
    end
    drive_host();
  endtask

  task automatic run_until_done(input string tag, input int maxc);
    int n = 0;
    while ((host_q.size() > 0 || exp_req_q.size() > 0 || exp_out_q.size() > 0 || io_busy) && n < maxc) begin
      cycle();
      n++;
    end
    check({tag, "_done_in_time"}, 64'(n < maxc), 64'd1);
    check({tag, "_busy_low"}, 64'(io_busy), 64'd0);
    check({tag, "_in_ready_high"}, 64'(io_host_in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] v;
    logic [31:0] w;
    int n;
    int base;

    for (int i = 0; i < 64; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
      scr_mem[i] = v;
    end
    ref_mem[5] = 64'h1122334455667788;
    scr_mem[5] = 64'h1122334455667788;

    reset             = 1'b0;
    io_host_in_valid  = 1'b0;
    io_host_in_bits   = '0;
    io_host_out_ready = 1'b1;
    io_smi_req_ready  = 1'b1;
    io_smi_resp_valid = 1'b0;
    io_smi_resp_bits  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(io_host_in_ready), 64'd1);
    check("rst_out_valid", 64'(io_host_out_valid), 64'd0);
    check("rst_req_valid", 64'(io_smi_req_valid), 64'd0);
    check("rst_resp_ready", 64'(io_smi_resp_ready), 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);
    check("rst_out_bits", 64'(io_host_out_bits), 64'd0);
    reset = 1'b1;
    repeat (2) cycle();

    // Read of addr 5 with latency checks
    send_read(32'h00000005);
    n = 0;
    do begin cycle(); n++; end while (!in_f && n < 10);
    check("rd_cmd_accepted", 64'(in_f), 64'd1);
    check("rd_req_at_t1", 64'(io_smi_req_valid), 64'd1);
    check("rd_req_addr", 64'(io_smi_req_bits_addr), 64'd5);
    check("rd_req_rw", 64'(io_smi_req_bits_rw), 64'd0);
    cycle();
    check("rd_resp_ready_t2", 64'(io_smi_resp_ready), 64'd1);
    check("rd_no_out_t2", 64'(io_host_out_valid), 64'd0);
    cycle();
    check("rd_out_valid_t3", 64'(io_host_out_valid), 64'd1);
    check("rd_out_lo", 64'(io_host_out_bits), 64'h55667788);
    cycle();
    check("rd_out_hi", 64'(io_host_out_bits), 64'h11223344);
    run_until_done("read5", 50);

    // Write of addr 63
    base = out_cnt;
    send_write(32'h8000003F, 32'hDEADBEEF, 32'hCAFEF00D);
    run_until_done("write63", 50);
    check("write_no_host_out", 64'(out_cnt - base), 64'd0);
    check("write_scr_value", scr_mem[63], 64'hCAFEF00DDEADBEEF);

    // Host-side backpressure on a read
    out_rdy_en = 1'b0;
    io_host_out_ready = 1'b0;
    send_read(32'h00000007);
    n = 0;
    while (!io_host_out_valid && n < 20) begin cycle(); n++; end
    check("bp_out_seen", 64'(io_host_out_valid), 64'd1);
    repeat (10) cycle();
    check("bp_out_still_valid", 64'(io_host_out_valid), 64'd1);
    check("bp_out_low_word", 64'(io_host_out_bits), 64'(ref_mem[7][31:0]));
    out_rdy_en = 1'b1;
    io_host_out_ready = 1'b1;
    run_until_done("bp_out", 50);

    // SMI-side backpressure on a write, with a read queued behind it
    req_rdy_en = 1'b0;
    io_smi_req_ready = 1'b0;
    send_write(32'h80000010, $urandom, $urandom);
    send_read(32'h00000010);
    n = 0;
    while (!io_smi_req_valid && n < 20) begin cycle(); n++; end
    check("bp_req_seen", 64'(io_smi_req_valid), 64'd1);
    repeat (5) cycle();
    check("bp_req_in_ready", 64'(io_host_in_ready), 64'd0);
    check("bp_req_addr", 64'(io_smi_req_bits_addr), 64'h10);
    req_rdy_en = 1'b1;
    io_smi_req_ready = 1'b1;
    run_until_done("bp_req", 80);

    // Non-rw upper bits are ignored
    send_read(32'h7FFFFFC2);
    run_until_done("ignored_bits", 50);

    // Stray response outside RESP is not accepted
    io_smi_resp_valid = 1'b1;
    io_smi_resp_bits  = 64'hFFFF0000FFFF0000;
    repeat (2) cycle();
    check("stray_resp_ready", 64'(io_smi_resp_ready), 64'd0);
    check("stray_busy", 64'(io_busy), 64'd0);
    io_smi_resp_valid = 1'b0;
    cycle();

    // Reset in WHI
    host_q.push_back(32'h80000001);
    host_q.push_back(32'h12345678);
    drive_host();
    n = 0;
    while (host_q.size() > 0 && n < 20) begin cycle(); n++; end
    check("mid_words_taken", 64'(host_q.size()), 64'd0);
    check("mid_busy_before", 64'(io_busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(io_host_in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(io_host_out_valid), 64'd0);
    check("mid_rst_req_valid", 64'(io_smi_req_valid), 64'd0);
    check("mid_rst_resp_ready", 64'(io_smi_resp_ready), 64'd0);
    check("mid_rst_busy", 64'(io_busy), 64'd0);
    check("mid_rst_out_bits", 64'(io_host_out_bits), 64'd0);
    check("mid_rst_req_rw", 64'(io_smi_req_bits_rw), 64'd0);
    check("mid_rst_req_addr", 64'(io_smi_req_bits_addr), 64'd0);
    check("mid_rst_req_data", io_smi_req_bits_data, 64'd0);
    stall_out_prev = 1'b0;
    stall_req_prev = 1'b0;
    io_smi_resp_valid = 1'b0;
    #1;
    reset = 1'b1;
    base = req_cnt;
    repeat (6) cycle();
    check("mid_no_req_after", 64'(req_cnt - base), 64'd0);
    send_read(32'h00000001);
    run_until_done("after_reset", 50);

    // Back-to-back stream of reads
    base = out_cnt;
    for (int a = 0; a < 4; a++) send_read(32'(a));
    run_until_done("stream", 100);
    check("stream_word_count", 64'(out_cnt - base), 64'd8);

    // Randomized traffic with random ready/valid gaps
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      w = $urandom;
      if (w[31]) send_write(w, $urandom, $urandom);
      else       send_read(w);
    end
    run_until_done("random", 3000);
    rand_rdy   = 1'b0;
    host_en    = 1'b1;
    io_smi_req_ready  = 1'b1;
    io_host_out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
